// File: rtl/uart_pkg.sv
// Shared types, frame layout constants and small helpers for the UART
// receive path. The frame is held LSB-first as {stop, parity, data, start}.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  localparam int FRAME_W    = 11;
  localparam int DATA_W     = 8;
  localparam int START_IDX  = 0;
  localparam int PARITY_IDX = 9;
  localparam int STOP_IDX   = 10;

  // Value presented on the parallel frame when nothing has been received:
  // start bit low, everything else at line-idle level.
  localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FE;

  // High when data XOR parity does not match the configured sense
  // (odd = 0 expects an even number of ones over data plus parity).
  function automatic logic parity_mismatch(input logic [FRAME_W-1:0] frame,
                                           input logic               odd);
    logic sum;
    sum = (^frame[PARITY_IDX-1:START_IDX+1]) ^ frame[PARITY_IDX];
    return (sum != odd);
  endfunction

  // Two-of-three vote used when the line is sampled three times per bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART receiver. Produces a strobe on the last
// count of a half-bit (half_sel = 1) or full-bit (half_sel = 0) period and
// a pre-strobe one cycle earlier. The counter wraps to zero on every strobe
// so consecutive periods chain without drift; clr holds it at zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic half_sel,
  output logic pre_tick,
  output logic tick
);

  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int HALF_LAST = (CLKS_PER_BIT / 2) - 1;
  localparam int FULL_LAST = CLKS_PER_BIT - 1;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] last_s;

  // Select the terminal count for the current period and decode strobes.
  always_comb begin
    last_s = CNT_W'(FULL_LAST);
    if (half_sel) begin
      last_s = CNT_W'(HALF_LAST);
    end else begin
      last_s = CNT_W'(FULL_LAST);
    end
    tick     = (cnt_r == last_s);
    pre_tick = (cnt_r == (last_s - CNT_W'(1)));
  end

  // Period counter: cleared while idle, wraps on each sample strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronizes the serial line, detects the start
// bit, samples 8 data bits, parity and stop at mid-bit and publishes the
// 11-bit frame {stop, parity, data, start} with a valid/ack handshake plus
// parity, framing and sticky overrun status.
// Build option: define UART_RX_MAJORITY_EN to take each bit as the 2-of-3
// vote of samples at mid-1, mid and mid+1 (decision one cycle later).
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_serial,
  input  logic                 frame_ack,
  output logic [FRAME_W-1:0]   data_parll,
  output logic                 frame_valid,
  output logic                 rx_busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  uart_rx_state_e     state_r;
  uart_rx_state_e     state_next;
  logic [2:0]         bit_cnt_r;
  logic [2:0]         bit_cnt_next;
  logic [FRAME_W-1:0] shift_r;
  logic               sync_meta_r;
  logic               rx_s;
  logic               pub_r;

  logic               clr_s;
  logic               half_sel_s;
  logic               pre_tick_s;
  logic               tick_s;
  logic               sample_valid_s;
  logic               sample_bit_s;
  logic               shift_en_s;
  logic               stop_done_s;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr_s),
    .half_sel (half_sel_s),
    .pre_tick (pre_tick_s),
    .tick     (tick_s)
  );

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta_r <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      sync_meta_r <= rx_serial;
      rx_s        <= sync_meta_r;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic maj_early_r;
  logic maj_mid_r;
  logic decide_r;

  // Capture the samples either side of mid-bit; vote the cycle after mid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      maj_early_r <= 1'b1;
      maj_mid_r   <= 1'b1;
      decide_r    <= 1'b0;
    end else begin
      if (pre_tick_s) begin
        maj_early_r <= rx_s;
      end else begin
        maj_early_r <= maj_early_r;
      end
      if (tick_s) begin
        maj_mid_r <= rx_s;
      end else begin
        maj_mid_r <= maj_mid_r;
      end
      decide_r <= tick_s && (state_r != IDLE);
    end
  end

  // Bit decision is the vote of mid-1, mid and the current (mid+1) sample.
  always_comb begin
    sample_valid_s = decide_r;
    sample_bit_s   = majority3(maj_early_r, maj_mid_r, rx_s);
  end
`else
  logic unused_pre_tick_s;
  assign unused_pre_tick_s = pre_tick_s;

  // Bit decision is the single synchronized sample at mid-bit.
  always_comb begin
    sample_valid_s = tick_s;
    sample_bit_s   = rx_s;
  end
`endif

  // Receive FSM: next state, bit counting and shift/publish strobes.
  always_comb begin
    state_next   = state_r;
    bit_cnt_next = bit_cnt_r;
    clr_s        = 1'b0;
    half_sel_s   = 1'b0;
    shift_en_s   = 1'b0;
    stop_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        clr_s = 1'b1;
        if (!rx_s) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        half_sel_s = 1'b1;
        if (sample_valid_s) begin
          if (sample_bit_s) begin
            // Line back high at mid start bit: treat as a glitch.
            state_next = IDLE;
          end else begin
            shift_en_s   = 1'b1;
            bit_cnt_next = 3'd0;
            state_next   = DATA;
          end
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (sample_valid_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == 3'(DATA_W - 1)) begin
            bit_cnt_next = 3'd0;
            state_next   = PARITY;
          end else begin
            bit_cnt_next = bit_cnt_r + 3'd1;
            state_next   = DATA;
          end
        end else begin
          state_next = DATA;
        end
      end
      PARITY: begin
        if (sample_valid_s) begin
          shift_en_s = 1'b1;
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end
      STOP: begin
        if (sample_valid_s) begin
          // Back to IDLE on the stop sample so a new start can follow at once.
          shift_en_s  = 1'b1;
          stop_done_s = 1'b1;
          state_next  = IDLE;
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = 3'd0;
      end
    endcase
  end

  // State, bit counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      bit_cnt_r <= 3'd0;
      rx_busy   <= 1'b0;
    end else begin
      state_r   <= state_next;
      bit_cnt_r <= bit_cnt_next;
      rx_busy   <= (state_next != IDLE);
    end
  end

  // Shift register: bits enter at the top so the start bit ends at bit 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_r <= IDLE_FRAME;
    end else if (shift_en_s) begin
      shift_r <= {sample_bit_s, shift_r[FRAME_W-1:1]};
    end else begin
      shift_r <= shift_r;
    end
  end

  // One-cycle delay from stop sample to publish.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pub_r <= 1'b0;
    end else begin
      pub_r <= stop_done_s;
    end
  end

  // Output holding register with valid/ack handshake and overrun tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_parll  <= IDLE_FRAME;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (pub_r) begin
      data_parll  <= shift_r;
      parity_err  <= parity_mismatch(shift_r, PARITY_ODD);
      frame_err   <= ~shift_r[STOP_IDX];
      frame_valid <= 1'b1;
      if (frame_valid && !frame_ack) begin
        overrun_err <= 1'b1;
      end else begin
        overrun_err <= overrun_err;
      end
    end else if (frame_valid && frame_ack) begin
      frame_valid <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      data_parll  <= data_parll;
      frame_valid <= frame_valid;
      parity_err  <= parity_err;
      frame_err   <= frame_err;
      overrun_err <= overrun_err;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl at 16 clocks per bit,
// even parity. Inputs are driven and outputs sampled on the falling edge.
module tb_uart_rx_ctrl;

  localparam int C = 16;
  localparam int LAT_EXP = 2 + C / 2 + 10 * C + 1;

  logic        clk;
  logic        reset_n;
  logic        rx_serial;
  logic        frame_ack;
  logic [10:0] data_parll;
  logic        frame_valid;
  logic        rx_busy;
  logic        parity_err;
  logic        frame_err;
  logic        overrun_err;

  int tests;
  int fails;
  int lat_meas;
  int busy_cnt;
  logic busy_mid;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (C),
    .PARITY_ODD   (1'b0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_serial   (rx_serial),
    .frame_ack   (frame_ack),
    .data_parll  (data_parll),
    .frame_valid (frame_valid),
    .rx_busy     (rx_busy),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one full frame; frame_ack is pulsed in the cycle index ack_cyc (-1 = never).
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int ack_cyc);
    logic [10:0] f;
    int cyc;
    f = {s, p, d, 1'b0};
    cyc = 0;
    lat_meas = -1;
    busy_mid = 1'b0;
    for (int b = 0; b < 11; b++) begin
      rx_serial = f[b];
      for (int j = 0; j < C; j++) begin
        frame_ack = (cyc == ack_cyc);
        @(negedge clk);
        cyc++;
        if (lat_meas < 0 && frame_valid) lat_meas = cyc - 1;
        if (cyc == 3 * C) busy_mid = rx_busy;
      end
    end
    frame_ack = 1'b0;
    rx_serial = 1'b1;
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    rx_serial = 1'b1;
    frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data_parll, 11'h7FE);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5, even parity 0, stop 1
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    check("a5_latency", lat_meas, LAT_EXP);
    check("a5_busy_mid", busy_mid, 1'b1);
    check("a5_data", data_parll, 11'h54A);
    check("a5_valid", frame_valid, 1'b1);
    check("a5_perr", parity_err, 1'b0);
    check("a5_ferr", frame_err, 1'b0);
    check("a5_busy_end", rx_busy, 1'b0);
    repeat (20) @(negedge clk);
    check("a5_hold_valid", frame_valid, 1'b1);
    check("a5_hold_data", data_parll, 11'h54A);
    pulse_ack();
    check("a5_acked", frame_valid, 1'b0);
    pulse_ack();
    check("idle_ack_valid", frame_valid, 1'b0);
    check("idle_ack_data", data_parll, 11'h54A);

    // 0x01 with wrong (even) parity bit 0
    send_frame(8'h01, 1'b0, 1'b1, -1);
    check("p01_data", data_parll, 11'h402);
    check("p01_perr", parity_err, 1'b1);
    check("p01_ferr", frame_err, 1'b0);
    pulse_ack();

    // 0x3C with stop bit 0
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    check("s3c_data", data_parll, 11'h078);
    check("s3c_ferr", frame_err, 1'b1);
    check("s3c_stopbit", data_parll[10], 1'b0);
    check("s3c_perr", parity_err, 1'b0);
    pulse_ack();
    repeat (20) @(negedge clk);

    // Back-to-back 0x11, 0x22 with no ack -> overrun
    send_frame(8'h11, 1'b0, 1'b1, -1);
    check("b11_data", data_parll, 11'h422);
    check("b11_ferr", frame_err, 1'b0);
    check("b11_ovr", overrun_err, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, -1);
    check("b22_data", data_parll[8:1], 8'h22);
    check("b22_valid", frame_valid, 1'b1);
    check("b22_ovr", overrun_err, 1'b1);
    pulse_ack();
    check("ovr_ack_valid", frame_valid, 1'b0);
    check("ovr_ack_ovr", overrun_err, 1'b0);

    // Ack coincident with the publish of the second frame -> no overrun
    send_frame(8'h11, 1'b0, 1'b1, -1);
    send_frame(8'h22, 1'b0, 1'b1, LAT_EXP);
    check("sim_data", data_parll, 11'h444);
    check("sim_valid", frame_valid, 1'b1);
    check("sim_ovr", overrun_err, 1'b0);
    pulse_ack();
    check("sim_acked", frame_valid, 1'b0);
    repeat (10) @(negedge clk);

    // 4-cycle low glitch
    busy_cnt = 0;
    rx_serial = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rx_serial = 1'b1;
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
    check("glitch_busy_cycles", busy_cnt, C / 2);
    check("glitch_valid", frame_valid, 1'b0);
    check("glitch_busy_end", rx_busy, 1'b0);

    // Reset mid-DATA with a held frame
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    check("pre_rst_valid", frame_valid, 1'b1);
    rx_serial = 1'b0;
    repeat (C) @(negedge clk);
    rx_serial = 1'b1;
    repeat (C) @(negedge clk);
    rx_serial = 1'b0;
    repeat (C) @(negedge clk);
    rx_serial = 1'b1;
    repeat (C) @(negedge clk);
    check("mid_busy", rx_busy, 1'b1);
    reset_n = 1'b0;
    rx_serial = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    check("mrst_data", data_parll, 11'h7FE);
    check("mrst_valid", frame_valid, 1'b0);
    check("mrst_busy", rx_busy, 1'b0);
    check("mrst_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    repeat (2 * C) @(negedge clk);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    check("r55_data", data_parll, 11'h4AA);
    check("r55_valid", frame_valid, 1'b1);
    check("r55_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    pulse_ack();
    check("r55_acked", frame_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
